// File: rtl/ctrl_pipe.sv
// Pipelined RV32I control path: ID decode, ID/EX, EX/MEM and MEM/WB control registers,
// load-use stall and branch flush. Define CTRL_ILLEGAL_TRAP_EN to add ex_illegal_o.
module ctrl_pipe #(
  parameter int ADDR_W         = 5,
  parameter int ALU_OP_W       = 3,
  parameter bit LOAD_USE_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         id_inst_i,
  input  logic                id_valid_i,
  input  logic                hold_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                ex_valid_o,
  output logic                ex_alu_src_o,
  output logic [ALU_OP_W-1:0] ex_alu_op_o,
  output logic [1:0]          ex_imm_src_o,
  output logic                ex_branch_o,
  output logic                ex_jump_o,
  output logic [ADDR_W-1:0]   ex_rd_o,
  output logic                mem_write_o,
  output logic                mem_read_o,
  output logic                wb_reg_write_o,
  output logic [1:0]          wb_result_src_o,
  output logic [ADDR_W-1:0]   wb_rd_o
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,output logic               ex_illegal_o
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'b000);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3'b001);

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic [1:0]          result_src;
    logic                mem_write;
    logic                mem_read;
    logic                branch;
    logic                jump;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          imm_src;
    logic [ADDR_W-1:0]   rd;
  } ctrl_t;

  // func3 to ALU op; the sub/add split is resolved by the caller.
  function automatic logic [ALU_OP_W-1:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_from_f3 = ALU_OP_W'(3'b000);
      3'b001:  alu_from_f3 = ALU_OP_W'(3'b110);
      3'b010:  alu_from_f3 = ALU_OP_W'(3'b101);
      3'b011:  alu_from_f3 = ALU_OP_W'(3'b101);
      3'b100:  alu_from_f3 = ALU_OP_W'(3'b100);
      3'b101:  alu_from_f3 = ALU_OP_W'(3'b111);
      3'b110:  alu_from_f3 = ALU_OP_W'(3'b011);
      default: alu_from_f3 = ALU_OP_W'(3'b010);
    endcase
  endfunction

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [ADDR_W-1:0] id_rd, id_rs1, id_rs2;
  logic              func7_ok;
  ctrl_t             dec;
  logic              dec_illegal;
  logic              uses_rs2;
  logic              hazard;

  ctrl_t             ex_q, ex_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_reg_write_q, mem_reg_write_d;
  logic [1:0]        mem_result_src_q, mem_result_src_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  logic [ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [1:0]        wb_result_src_q, wb_result_src_d;
  logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;

  assign opcode   = id_inst_i[6:0];
  assign f3       = id_inst_i[14:12];
  assign id_rd    = ADDR_W'(id_inst_i[11:7]);
  assign id_rs1   = ADDR_W'(id_inst_i[19:15]);
  assign id_rs2   = ADDR_W'(id_inst_i[24:20]);
  assign func7_ok = (id_inst_i[31:25] == 7'b0000000) || (id_inst_i[31:25] == 7'b0100000);
  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        if (func7_ok) begin
          dec.reg_write = 1'b1;
          dec.rd        = id_rd;
          dec.alu_op    = (f3 == 3'b000 && id_inst_i[30]) ? ALU_SUB : alu_from_f3(f3);
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_I_ALU: begin
        dec.reg_write = 1'b1;
        dec.rd        = id_rd;
        dec.alu_src   = 1'b1;
        dec.alu_op    = alu_from_f3(f3);
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.rd         = id_rd;
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALU_ADD;
        dec.mem_read   = 1'b1;
        dec.result_src = 2'b01;
      end
      OP_STORE: begin
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.imm_src   = 2'b01;
        dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.alu_op  = ALU_SUB;
        dec.imm_src = 2'b10;
      end
      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.rd         = id_rd;
        dec.imm_src    = 2'b11;
        dec.result_src = 2'b10;
      end
      OP_JALR: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.rd         = id_rd;
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALU_ADD;
        dec.result_src = 2'b10;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // id_valid_i qualifies id_inst_i; while stall_o is high the same instruction must be
  // re-presented next cycle, and it is consumed on the first cycle stall_o is low.
  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid_i &&
                  ((ex_q.rd == id_rs1) || (uses_rs2 && (ex_q.rd == id_rs2)));
  assign stall_o = LOAD_USE_CHECK && !flush_i && hazard;

  always_comb begin
    ex_d             = ex_q;
    mem_valid_d      = mem_valid_q;
    mem_reg_write_d  = mem_reg_write_q;
    mem_result_src_d = mem_result_src_q;
    mem_write_d      = mem_write_q;
    mem_read_d       = mem_read_q;
    mem_rd_d         = mem_rd_q;
    wb_valid_d       = wb_valid_q;
    wb_reg_write_d   = wb_reg_write_q;
    wb_result_src_d  = wb_result_src_q;
    wb_rd_d          = wb_rd_q;
    if (!hold_i) begin
      if (flush_i || stall_o || !id_valid_i) begin
        ex_d = '0;
      end else begin
        ex_d       = dec;
        ex_d.valid = 1'b1;
      end
      mem_valid_d      = ex_q.valid;
      mem_reg_write_d  = ex_q.reg_write;
      mem_result_src_d = ex_q.result_src;
      mem_write_d      = ex_q.mem_write;
      mem_read_d       = ex_q.mem_read;
      mem_rd_d         = ex_q.rd;
      wb_valid_d       = mem_valid_q;
      wb_reg_write_d   = mem_reg_write_q;
      wb_result_src_d  = mem_result_src_q;
      wb_rd_d          = mem_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q             <= '0;
      mem_valid_q      <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_result_src_q <= 2'b00;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_rd_q         <= '0;
      wb_valid_q       <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_result_src_q  <= 2'b00;
      wb_rd_q          <= '0;
    end else begin
      ex_q             <= ex_d;
      mem_valid_q      <= mem_valid_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_result_src_q <= mem_result_src_d;
      mem_write_q      <= mem_write_d;
      mem_read_q       <= mem_read_d;
      mem_rd_q         <= mem_rd_d;
      wb_valid_q       <= wb_valid_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_result_src_q  <= wb_result_src_d;
      wb_rd_q          <= wb_rd_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ex_illegal_q, ex_illegal_d;

  always_comb begin
    ex_illegal_d = ex_illegal_q;
    if (!hold_i) ex_illegal_d = id_valid_i && dec_illegal && !flush_i && !stall_o;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ex_illegal_q <= 1'b0;
    else        ex_illegal_q <= ex_illegal_d;
  end

  assign ex_illegal_o = ex_illegal_q;
`endif

  assign ex_valid_o      = ex_q.valid;
  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_imm_src_o    = ex_q.imm_src;
  assign ex_branch_o     = ex_q.branch;
  assign ex_jump_o       = ex_q.jump;
  assign ex_rd_o         = ex_q.rd;
  assign mem_write_o     = mem_valid_q && mem_write_q;
  assign mem_read_o      = mem_valid_q && mem_read_q;
  assign wb_reg_write_o  = wb_valid_q && wb_reg_write_q && (wb_rd_q != '0);
  assign wb_result_src_o = wb_result_src_q;
  assign wb_rd_o         = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: reset, decode, latency, load-use, flush, hold, x0/illegal.
module tb_ctrl_pipe;

  localparam logic [31:0] I_ADD     = 32'h002081B3;
  localparam logic [31:0] I_SUB     = 32'h402081B3;
  localparam logic [31:0] I_LW      = 32'h0000A103;
  localparam logic [31:0] I_SW      = 32'h0020A023;
  localparam logic [31:0] I_ADDI_HI = 32'h40008193;
  localparam logic [31:0] I_ADDI_R1 = 32'h00208193;
  localparam logic [31:0] I_ADDI_R2 = 32'h00010193;
  localparam logic [31:0] I_LW_X0   = 32'h00002003;
  localparam logic [31:0] I_ADD_X0S = 32'h000001B3;
  localparam logic [31:0] I_BEQ     = 32'h00208463;
  localparam logic [31:0] I_JAL     = 32'h008000EF;
  localparam logic [31:0] I_ADD_X5  = 32'h002082B3;
  localparam logic [31:0] I_ADD_X6  = 32'h00208333;
  localparam logic [31:0] I_ADD_X7  = 32'h002083B3;
  localparam logic [31:0] I_ADD_X8  = 32'h00208433;
  localparam logic [31:0] I_ADDI_X0 = 32'h00000013;
  localparam logic [31:0] I_OP7F    = 32'h0000007F;
  localparam logic [31:0] I_BAD_F7  = 32'h202081B3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_inst;
  logic        id_valid, hold, flush;
  logic        stall, ex_valid, ex_alu_src, ex_branch, ex_jump;
  logic [2:0]  ex_alu_op;
  logic [1:0]  ex_imm_src, wb_result_src;
  logic [4:0]  ex_rd, wb_rd;
  logic        mem_write, mem_read, wb_reg_write;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_rd;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_inst_i(id_inst), .id_valid_i(id_valid),
    .hold_i(hold), .flush_i(flush), .stall_o(stall), .ex_valid_o(ex_valid),
    .ex_alu_src_o(ex_alu_src), .ex_alu_op_o(ex_alu_op), .ex_imm_src_o(ex_imm_src),
    .ex_branch_o(ex_branch), .ex_jump_o(ex_jump), .ex_rd_o(ex_rd),
    .mem_write_o(mem_write), .mem_read_o(mem_read), .wb_reg_write_o(wb_reg_write),
    .wb_result_src_o(wb_result_src), .wb_rd_o(wb_rd)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,.ex_illegal_o(ex_illegal)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b1; flush = 1'b0; id_valid = 1'b1; id_inst = I_ADD;
    step(); step();
    rst_n = 1'b1;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    total++; if ({ex_alu_src, ex_alu_op, ex_imm_src, ex_branch, ex_jump, ex_rd} !== 13'd0) begin bad++; $display("FAIL reset_ex_fields got=%h exp=0", {ex_alu_src, ex_alu_op, ex_imm_src, ex_branch, ex_jump, ex_rd}); end
    total++; if ({mem_write, mem_read, wb_reg_write, wb_result_src, wb_rd, stall} !== 11'd0) begin bad++; $display("FAIL reset_mem_wb got=%h exp=0", {mem_write, mem_read, wb_reg_write, wb_result_src, wb_rd, stall}); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_ex_valid got=%b exp=0", ex_valid); end
    hold = 1'b0; idle(1);
  endtask

  task automatic test_add_sub();
    id_valid = 1'b1; id_inst = I_ADD; step();
    total++; if ({ex_valid, ex_alu_src, ex_alu_op, ex_rd} !== {1'b1, 1'b0, 3'b000, 5'd3}) begin bad++; $display("FAIL add_ex got=%h exp=%h", {ex_valid, ex_alu_src, ex_alu_op, ex_rd}, {1'b1, 1'b0, 3'b000, 5'd3}); end
    id_inst = I_SUB; step();
    total++; if (ex_alu_op !== 3'b001) begin bad++; $display("FAIL sub_alu_op got=%b exp=001", ex_alu_op); end
    total++; if ({mem_write, mem_read} !== 2'b00) begin bad++; $display("FAIL add_mem got=%b exp=00", {mem_write, mem_read}); end
    id_valid = 1'b0; step();
    total++; if ({wb_reg_write, wb_rd, wb_result_src} !== {1'b1, 5'd3, 2'b00}) begin bad++; $display("FAIL add_wb got=%h exp=%h", {wb_reg_write, wb_rd, wb_result_src}, {1'b1, 5'd3, 2'b00}); end
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL add_ex_drain got=%b exp=0", ex_valid); end
    idle(3);
  endtask

  task automatic test_decode();
    id_valid = 1'b1; id_inst = I_ADDI_HI; step();
    total++; if ({ex_alu_op, ex_alu_src, ex_imm_src} !== {3'b000, 1'b1, 2'b00}) begin bad++; $display("FAIL addi_no_sub got=%b exp=000100", {ex_alu_op, ex_alu_src, ex_imm_src}); end
    id_inst = I_BEQ; step();
    total++; if ({ex_branch, ex_alu_op, ex_imm_src, ex_alu_src} !== {1'b1, 3'b001, 2'b10, 1'b0}) begin bad++; $display("FAIL beq got=%b exp=1001100", {ex_branch, ex_alu_op, ex_imm_src, ex_alu_src}); end
    id_inst = I_JAL; step();
    total++; if ({ex_jump, ex_imm_src, ex_rd} !== {1'b1, 2'b11, 5'd1}) begin bad++; $display("FAIL jal got=%b exp=11100001", {ex_jump, ex_imm_src, ex_rd}); end
    id_inst = I_SW; step();
    total++; if ({ex_alu_op, ex_alu_src, ex_imm_src, ex_branch, ex_jump} !== {3'b000, 1'b1, 2'b01, 1'b0, 1'b0}) begin bad++; $display("FAIL sw_ex got=%b exp=000101 00", {ex_alu_op, ex_alu_src, ex_imm_src, ex_branch, ex_jump}); end
    id_valid = 1'b0; step();
    total++; if ({mem_write, mem_read} !== 2'b10) begin bad++; $display("FAIL sw_mem got=%b exp=10", {mem_write, mem_read}); end
    total++; if ({wb_reg_write, wb_result_src, wb_rd} !== {1'b1, 2'b10, 5'd1}) begin bad++; $display("FAIL jal_wb got=%h exp=%h", {wb_reg_write, wb_result_src, wb_rd}, {1'b1, 2'b10, 5'd1}); end
    idle(3);
  endtask

  task automatic test_load_use();
    id_valid = 1'b1; id_inst = I_LW; step();
    id_inst = I_ADD; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
    step();
    total++; if ({ex_valid, mem_read} !== 2'b01) begin bad++; $display("FAIL lu_bubble got=%b exp=01", {ex_valid, mem_read}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%b exp=0", stall); end
    step();
    total++; if ({ex_valid, ex_rd, ex_alu_op} !== {1'b1, 5'd3, 3'b000}) begin bad++; $display("FAIL lu_add_ex got=%h exp=%h", {ex_valid, ex_rd, ex_alu_op}, {1'b1, 5'd3, 3'b000}); end
    total++; if ({wb_reg_write, wb_rd, wb_result_src} !== {1'b1, 5'd2, 2'b01}) begin bad++; $display("FAIL lu_lw_wb got=%h exp=%h", {wb_reg_write, wb_rd, wb_result_src}, {1'b1, 5'd2, 2'b01}); end
    id_inst = I_LW; step();
    id_inst = I_ADDI_R1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_rs2_unused got=%b exp=0", stall); end
    step();
    id_inst = I_LW; step();
    id_inst = I_ADDI_R2; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_rs1 got=%b exp=1", stall); end
    step(); step();
    id_inst = I_LW_X0; step();
    id_inst = I_ADD_X0S; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_rd0 got=%b exp=0", stall); end
    id_inst = I_ADD; id_valid = 1'b0; step();
    id_inst = I_LW; id_valid = 1'b1; step();
    id_inst = I_ADD; id_valid = 1'b0; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_id_invalid got=%b exp=0", stall); end
    idle(4);
  endtask

  task automatic test_flush();
    id_valid = 1'b1; id_inst = I_LW; step();
    id_inst = I_ADD; flush = 1'b1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_masks_stall got=%b exp=0", stall); end
    step();
    total++; if ({ex_valid, mem_read} !== 2'b01) begin bad++; $display("FAIL flush_bubble got=%b exp=01", {ex_valid, mem_read}); end
    id_inst = I_SW; step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_sw_ex got=%b exp=0", ex_valid); end
    flush = 1'b0; id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL flush_sw_mem cyc=%0d got=%b exp=0", i, mem_write); end
    end
  endtask

  task automatic test_hold();
    id_valid = 1'b1;
    id_inst = I_ADD_X5; step();
    id_inst = I_ADD_X6; step();
    id_inst = I_ADD_X7; step();
    id_inst = I_ADD_X8; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({ex_valid, ex_rd, wb_reg_write, wb_rd} !== {1'b1, 5'd7, 1'b1, 5'd5}) begin bad++; $display("FAIL hold_frozen cyc=%0d got=%h exp=%h", i, {ex_valid, ex_rd, wb_reg_write, wb_rd}, {1'b1, 5'd7, 1'b1, 5'd5}); end
    end
    hold = 1'b0;
    exp_q.push_back(5'd6); exp_q.push_back(5'd7); exp_q.push_back(5'd8);
    step();
    total++; if (ex_rd !== 5'd8) begin bad++; $display("FAIL hold_release_ex got=%0d exp=8", ex_rd); end
    id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_rd = exp_q.pop_front();
      total++; if ({wb_reg_write, wb_rd} !== {1'b1, exp_rd}) begin bad++; $display("FAIL hold_wb_seq cyc=%0d got=%h exp=%h", i, {wb_reg_write, wb_rd}, {1'b1, exp_rd}); end
      step();
    end
    idle(1);
  endtask

  task automatic test_x0_illegal();
    id_valid = 1'b1; id_inst = I_ADDI_X0; step();
    id_inst = I_OP7F; step();
    total++; if ({ex_alu_src, ex_branch, ex_jump, ex_rd, ex_alu_op, ex_imm_src} !== 13'd0) begin bad++; $display("FAIL illegal_nop got=%h exp=0", {ex_alu_src, ex_branch, ex_jump, ex_rd, ex_alu_op, ex_imm_src}); end
`ifdef CTRL_ILLEGAL_TRAP_EN
    total++; if (ex_illegal !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%b exp=1", ex_illegal); end
`endif
    id_valid = 1'b0; step();
    total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL x0_wb got=%b exp=0", wb_reg_write); end
`ifdef CTRL_ILLEGAL_TRAP_EN
    total++; if (ex_illegal !== 1'b0) begin bad++; $display("FAIL illegal_one_cycle got=%b exp=0", ex_illegal); end
`endif
    total++; if ({mem_write, mem_read} !== 2'b00) begin bad++; $display("FAIL illegal_mem got=%b exp=00", {mem_write, mem_read}); end
    id_valid = 1'b1; id_inst = I_BAD_F7; step();
    total++; if ({ex_rd, ex_alu_op} !== 8'd0) begin bad++; $display("FAIL bad_f7_nop got=%h exp=0", {ex_rd, ex_alu_op}); end
`ifdef CTRL_ILLEGAL_TRAP_EN
    total++; if (ex_illegal !== 1'b1) begin bad++; $display("FAIL bad_f7_flag got=%b exp=1", ex_illegal); end
    id_inst = I_OP7F; flush = 1'b1; step();
    total++; if (ex_illegal !== 1'b0) begin bad++; $display("FAIL illegal_flush got=%b exp=0", ex_illegal); end
    flush = 1'b0;
`endif
    idle(3);
    total++; if (wb_reg_write !== 1'b0) begin bad++; $display("FAIL illegal_wb got=%b exp=0", wb_reg_write); end
  endtask

  task automatic test_reset_mid();
    id_valid = 1'b1; id_inst = I_LW; step();
    id_inst = I_SW; step();
    rst_n = 1'b0; hold = 1'b1; step();
    total++; if ({ex_valid, mem_read, mem_write, wb_reg_write, wb_rd} !== 9'd0) begin bad++; $display("FAIL reset_mid got=%h exp=0", {ex_valid, mem_read, mem_write, wb_reg_write, wb_rd}); end
    rst_n = 1'b1; hold = 1'b0; id_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({mem_write, mem_read, wb_reg_write} !== 3'b000) begin bad++; $display("FAIL reset_mid_drain cyc=%0d got=%b exp=000", i, {mem_write, mem_read, wb_reg_write}); end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_decode();
    test_load_use();
    test_flush();
    test_hold();
    test_x0_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the single-cycle control path for the RV32I core.
- Decodes the ID-stage instruction into a control bundle, then carries it through the ID/EX, EX/MEM and MEM/WB registers with per-stage valid bits.
- Detects load-use hazards, applies stalls and branch flushes, and drives stage-local control to the datapath.

Parameters:
- ADDR_W, 5, register-index width (rs1/rs2/rd).
- ALU_OP_W, 3, ALU operation code width.
- LOAD_USE_CHECK, 1, 1 enables internal load-use stall generation; 0 ties stall_o low.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset: synchronous and active-low.
- id_inst_i  in  32  instruction in ID stage.
- id_valid_i  in  1  id_inst_i holds a real instruction.
- hold_i  in  1  external freeze of all pipeline registers (memory wait).
- flush_i  in  1  EX-resolved taken branch/jump; squash ID.
- stall_o  out  1  load-use stall request to PC/IF-ID (combinational).
- ex_valid_o  out  1  ID/EX holds a live instruction.
- ex_alu_src_o  out  1  1 = immediate operand.
- ex_alu_op_o  out  ALU_OP_W  ALU operation code.
- ex_imm_src_o  out  2  immediate format code.
- ex_branch_o  out  1  conditional branch in EX.
- ex_jump_o  out  1  jal/jalr in EX.
- ex_rd_o  out  ADDR_W  rd in EX.
- mem_write_o  out  1  store in MEM (qualified by valid).
- mem_read_o  out  1  load in MEM (qualified by valid).
- wb_reg_write_o  out  1  register write in WB (qualified, 0 if rd==0).
- wb_result_src_o  out  2  00 ALU, 01 memory, 10 PC+4.
- wb_rd_o  out  ADDR_W  rd in WB.

Behaviour:
- Decode is combinational on opcode inst[6:0], func3 inst[14:12] and func7 bit inst[30].
- Opcode classes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr. Any other opcode decodes as a NOP (all enables 0).
- alu_op encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
  - R type with func3=000 and inst[30]=1 gives sub.
  - I-ALU never gives sub.
  - Load, store and jalr force add; branch forces sub.
- imm_src encoding: 00 I, 01 S, 10 B, 11 J.
- Pipeline advance: ID→EX, EX→MEM and MEM→WB registers update each cycle unless hold_i=1. With hold_i=1 every register holds, including valid bits.
- Load-use hazard (LOAD_USE_CHECK=1): stall_o=1 when all of the following hold:
  - ex_valid and the EX instruction is a load;
  - ex_rd≠0;
  - id_valid_i=1;
  - ex_rd equals rs1, or equals rs2 and the ID instruction uses rs2 (R, store, branch).
  - Effect: one bubble (valid=0, enables 0) enters ID/EX; EX/MEM and MEM/WB advance normally.
- flush_i=1 (without hold_i): a bubble enters ID/EX regardless of the decoded instruction. stall_o is forced to 0 that cycle.
- Priority: hold_i > flush_i > load-use stall.
- Each write enable (mem_write_o, mem_read_o, wb_reg_write_o) is ANDed with its stage valid bit. wb_reg_write_o is also forced to 0 when wb_rd_o is 0.
- Latency: a decoded instruction appears on the ex_* outputs 1 cycle after capture, on mem_* after 2 cycles and on wb_* after 3 cycles, with no hold.
- Reset: on a rising clk edge with rst_n=0, every stage register clears. All valid bits and all outputs go to 0, including rd and codes.
  - Reset overrides hold_i.
  - Reset mid-operation discards in-flight instructions with no partial writes.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output ex_illegal_o (1 bit). It is registered with the ID/EX stage and set when a valid instruction has an unlisted opcode, or R type with inst[31:25] not equal to 0000000/0100000.
  - The instruction still proceeds as a NOP.
  - ex_illegal_o is cleared by reset and by flush bubbles.
- Undefined: the port is absent and illegal encodings are silent NOPs.

Test Plan:
- Reset: rst_n=0 for 2 cycles with hold_i=1 and valid instructions driven -> all outputs 0 at the first post-reset sample.
- ADD/SUB: 0x002081B3 (add x3,x1,x2) then 0x402081B3 (sub) -> ex_alu_op 000 then 001. Cycle 3: wb_reg_write_o=1, wb_rd_o=3, wb_result_src_o=00.
- Load-use: 0x0000A103 (lw x2,0(x1)) followed by 0x002081B3 -> stall_o=1 for exactly 1 cycle.
  - Bubble in EX (ex_valid_o=0).
  - add reaches EX one cycle later.
  - mem_read_o=1 on the lw's MEM cycle.
- Flush: flush_i=1 with a store (0x0020A023) in ID -> ex_valid_o=0 next cycle; mem_write_o never asserts for that store.
- Hold: hold_i=1 for 3 cycles mid-stream -> all stage outputs constant. Release -> sequence resumes with no loss or duplication.
- x0 destination and illegal opcode: 0x00000013 (addi x0) -> wb_reg_write_o=0. Opcode 0x7F -> NOP; with CTRL_ILLEGAL_TRAP_EN, ex_illegal_o=1 for one cycle.
